// File: rtl/cpu_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_controller_if                                                        |
// | Opcode/status inputs and datapath/memory strobes of the CPU sequencer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       PC_addr;
    logic       PC_actve;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       ld_ac;
    logic       ld_pc;
    logic       inc_pc;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    // The sequencer is the master: it consumes status and drives the strobes.
    modport master (
        input  opcode, zero,
        output PC_addr, PC_actve, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc,
               data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  PC_addr, PC_actve, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc,
               data_e, halt, phase
    );
endinterface
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_controller                                                           |
// | Eight-phase instruction sequencer with a sticky halt state.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cpu_controller (
    input  wire              clk,
    input  wire              rst_n,
    cpu_controller_if.master bus
);

    localparam logic [2:0] c_PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] c_PH_INST_FETCH = 3'd1;
    localparam logic [2:0] c_PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] c_PH_IDLE       = 3'd3;
    localparam logic [2:0] c_PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] c_PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] c_PH_ALU_OP     = 3'd6;
    localparam logic [2:0] c_PH_STORE      = 3'd7;

    localparam logic [2:0] c_OP_HLT = 3'b000;
    localparam logic [2:0] c_OP_SKZ = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_LDA = 3'b101;
    localparam logic [2:0] c_OP_STO = 3'b110;
    localparam logic [2:0] c_OP_JMP = 3'b111;

    logic [2:0] r_phase;
    logic       r_halted;

    logic w_aluop;
    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;

    logic w_pc_addr;
    logic w_pc_actve;
    logic w_rd;
    logic w_wr;
    logic w_ld_ir;
    logic w_ld_ac;
    logic w_ld_pc;
    logic w_inc_pc;
    logic w_data_e;
    logic w_halt;

    assign w_aluop  = (bus.opcode == c_OP_ADD) || (bus.opcode == c_OP_AND) ||
                      (bus.opcode == c_OP_XOR) || (bus.opcode == c_OP_LDA);
    assign w_is_hlt = (bus.opcode == c_OP_HLT);
    assign w_is_skz = (bus.opcode == c_OP_SKZ);
    assign w_is_sto = (bus.opcode == c_OP_STO);
    assign w_is_jmp = (bus.opcode == c_OP_JMP);

    // HLT freezes the phase at OP_ADDR; only reset leaves the halted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= c_PH_INST_ADDR;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (r_phase == c_PH_OP_ADDR && w_is_hlt) begin
                r_halted <= 1'b1;
            end else begin
                r_phase <= r_phase + 3'd1;
            end
        end
    end

    always_comb begin
        w_pc_addr  = 1'b0;
        w_pc_actve = 1'b0;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_ld_ir    = 1'b0;
        w_ld_ac    = 1'b0;
        w_ld_pc    = 1'b0;
        w_inc_pc   = 1'b0;
        w_data_e   = 1'b0;
        w_halt     = 1'b0;
        if (r_halted) begin
            w_pc_addr = 1'b1;
            w_halt    = 1'b1;
        end else begin
            case (r_phase)
                c_PH_INST_ADDR: begin
                    w_pc_actve = 1'b1;
                end
                c_PH_INST_FETCH: begin
                    w_rd = 1'b1;
                end
                c_PH_INST_LOAD, c_PH_IDLE: begin
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                c_PH_OP_ADDR: begin
                    w_pc_addr  = 1'b1;
                    w_pc_actve = 1'b1;
                    w_halt     = w_is_hlt;
                    w_inc_pc   = !w_is_hlt;
                end
                c_PH_OP_FETCH: begin
                    w_pc_addr = 1'b1;
                    w_rd      = w_aluop;
                end
                c_PH_ALU_OP: begin
                    w_pc_addr = 1'b1;
                    w_rd      = w_aluop;
                    w_inc_pc  = w_is_skz && bus.zero;
                    w_ld_pc   = w_is_jmp;
                    w_data_e  = w_is_sto;
                end
                c_PH_STORE: begin
                    // wr sits inside the two-cycle data_e window.
                    w_pc_addr = 1'b1;
                    w_rd      = w_aluop;
                    w_ld_pc   = w_is_jmp;
                    w_ld_ac   = w_aluop;
                    w_data_e  = w_is_sto;
                    w_wr      = w_is_sto;
                end
                default: begin
                    w_pc_addr = 1'b0;
                end
            endcase
        end
    end

    assign bus.PC_addr  = w_pc_addr;
    assign bus.PC_actve = w_pc_actve;
    assign bus.rd       = w_rd;
    assign bus.wr       = w_wr;
    assign bus.ld_ir    = w_ld_ir;
    assign bus.ld_ac    = w_ld_ac;
    assign bus.ld_pc    = w_ld_pc;
    assign bus.inc_pc   = w_inc_pc;
    assign bus.data_e   = w_data_e;
    assign bus.halt     = w_halt;
    assign bus.phase    = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_controller                                                        |
// | Table-driven phase-by-phase check of the sequencer with a scoreboard.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_controller;

    logic clk;
    logic rst_n;

    cpu_controller_if bus ();

    cpu_controller u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instruction expectation: one bit per phase for each strobe.
    typedef struct {
        logic [2:0] opc;
        logic       z;
        string      name;
        logic [7:0] m_rd;
        logic [7:0] m_wr;
        logic [7:0] m_ir;
        logic [7:0] m_ac;
        logic [7:0] m_pc;
        logic [7:0] m_inc;
        logic [7:0] m_de;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] w;
    } sb_t;

    localparam logic [7:0] c_ADDR_M = 8'hF0;
    localparam logic [7:0] c_ACT_M  = 8'h11;

    sb_t  sb_q[$];
    vec_t tbl[10];
    int   n_checks;
    int   n_fail;

    // {PC_addr, PC_actve, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase}
    function automatic logic [12:0] mk(input logic a, input logic act, input logic r,
                                        input logic w, input logic ir, input logic ac,
                                        input logic pc, input logic inc, input logic de,
                                        input logic h, input logic [2:0] ph);
        return {a, act, r, w, ir, ac, pc, inc, de, h, ph};
    endfunction

    function automatic logic [12:0] exp_from(input vec_t v, input int ph);
        return mk(c_ADDR_M[ph], c_ACT_M[ph], v.m_rd[ph], v.m_wr[ph], v.m_ir[ph],
                  v.m_ac[ph], v.m_pc[ph], v.m_inc[ph], v.m_de[ph], 1'b0, 3'(ph));
    endfunction

    function automatic vec_t mkv(input logic [2:0] opc, input logic z, input string nm,
                                 input logic [7:0] r, input logic [7:0] w,
                                 input logic [7:0] ac, input logic [7:0] pc,
                                 input logic [7:0] inc, input logic [7:0] de);
        vec_t v;
        v.opc = opc; v.z = z; v.name = nm;
        v.m_rd = r; v.m_wr = w; v.m_ir = 8'h0C; v.m_ac = ac;
        v.m_pc = pc; v.m_inc = inc; v.m_de = de;
        return v;
    endfunction

    function automatic logic [12:0] actual();
        return {bus.PC_addr, bus.PC_actve, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
                bus.ld_pc, bus.inc_pc, bus.data_e, bus.halt, bus.phase};
    endfunction

    task automatic push(input string nm, input logic [12:0] w);
        sb_t e;
        e.name = nm;
        e.w    = w;
        sb_q.push_back(e);
    endtask

    task automatic check_pop();
        sb_t e;
        logic [12:0] a;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got output with no expectation queued");
        end else begin
            e = sb_q.pop_front();
            a = actual();
            if (a !== e.w) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, a, e.w);
            end
        end
    endtask

    // Drives one instruction from phase 0; checks phases 0..last_ph.
    task automatic run_vec(input vec_t v, input int last_ph);
        for (int p = 0; p <= last_ph; p++)
            push($sformatf("%s_ph%0d", v.name, p), exp_from(v, p));
        for (int p = 0; p <= last_ph; p++) begin
            @(negedge clk);
            if (p == 0) begin
                bus.opcode = v.opc;
                bus.zero   = v.z;
            end
            #1 check_pop();
        end
    endtask

    // Assert reset between edges, check the asynchronous effect, release after the next edge.
    task automatic async_reset(input string nm);
        #1 rst_n = 1'b0;
        #1 push(nm, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        check_pop();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vec_t v_hlt;
        n_checks = 0;
        n_fail   = 0;
        rst_n      = 1'b0;
        bus.opcode = 3'b010;
        bus.zero   = 1'b0;

        //            opc     z     name        rd     wr     ac     pc     inc    de
        tbl[0] = mkv(3'b010, 1'b0, "ADD",     8'hEE, 8'h00, 8'h80, 8'h00, 8'h10, 8'h00);
        tbl[1] = mkv(3'b011, 1'b1, "AND",     8'hEE, 8'h00, 8'h80, 8'h00, 8'h10, 8'h00);
        tbl[2] = mkv(3'b100, 1'b0, "XOR",     8'hEE, 8'h00, 8'h80, 8'h00, 8'h10, 8'h00);
        tbl[3] = mkv(3'b101, 1'b1, "LDA",     8'hEE, 8'h00, 8'h80, 8'h00, 8'h10, 8'h00);
        tbl[4] = mkv(3'b001, 1'b1, "SKZ_z1",  8'h0E, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00);
        tbl[5] = mkv(3'b001, 1'b0, "SKZ_z0",  8'h0E, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00);
        tbl[6] = mkv(3'b110, 1'b0, "STO",     8'h0E, 8'h80, 8'h00, 8'h00, 8'h10, 8'hC0);
        tbl[7] = mkv(3'b110, 1'b1, "STO_z1",  8'h0E, 8'h80, 8'h00, 8'h00, 8'h10, 8'hC0);
        tbl[8] = mkv(3'b111, 1'b0, "JMP",     8'h0E, 8'h00, 8'h00, 8'hC0, 8'h10, 8'h00);
        tbl[9] = mkv(3'b111, 1'b1, "JMP_z1",  8'h0E, 8'h00, 8'h00, 8'hC0, 8'h10, 8'h00);
        v_hlt  = mkv(3'b000, 1'b0, "HLT",     8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state while rst_n is held low across clock edges.
        repeat (3) @(posedge clk);
        #2 push("reset_state", mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        check_pop();
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i], 7);

        // STO interrupted by reset in phase 6, then ADD must sequence normally.
        run_vec(tbl[6], 6);
        async_reset("reset_in_sto_ph6");
        run_vec(tbl[0], 7);

        // HLT: phases 0..3 normal, phase 4 halts, then frozen regardless of inputs.
        run_vec(v_hlt, 3);
        push("hlt_ph4", mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
        @(negedge clk);
        #1 check_pop();
        for (int c = 0; c < 20; c++) begin
            push($sformatf("halted_cyc%0d", c),
                 mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4));
            @(negedge clk);
            bus.opcode = 3'($urandom_range(7, 0));
            bus.zero   = 1'($urandom_range(1, 0));
            #1 check_pop();
        end

        async_reset("reset_while_halted");
        run_vec(tbl[4], 7);
        run_vec(tbl[6], 7);

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
